// File: rtl/pid_cmd_parser.sv
// pid_cmd_parser
// ASCII command decoder between the UART byte receiver/transmitter and the
// PID register bank / auto-tuner of NUM_CH motor channels.
//
// Commands (each terminated by CR, LF ignored while parsing):
//   <K|I|D|S><ch><NDIG hex digits>  write gain/setpoint -> 'A' or 'N'
//   T<ch>                           start auto-tune     -> 'A' or 'N'
//   R<ch><K|I|D|S>                  read back           -> NDIG hex chars + CR
//
// Ports:
//   CLK, RST_N          clock, synchronous active-low reset
//   rx_data, rx_valid   received byte with one-cycle strobe
//   tx_data, tx_valid,  response byte stream
//   tx_ready
//   wr_en, wr_ch,       one-cycle register write strobe with channel,
//   wr_sel, wr_data     selector (0=Kp 1=Ki 2=Kd 3=setpoint) and value
//   rd_req, rd_data     one-cycle read strobe (uses wr_ch/wr_sel); rd_data
//                       is captured one cycle after the strobe
//   tune_start, tune_ch one-cycle auto-tune start strobe with channel
//   overrun             sticky: a byte arrived while a response was pending
//
// TX handshake: a byte transfers on a cycle where tx_valid && tx_ready.
// Once tx_valid is raised, it and tx_data hold until that transfer happens
// (only reset can withdraw it); at most one byte moves per cycle.

module pid_cmd_parser #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              wr_en,
    output logic [CH_W-1:0]   wr_ch,
    output logic [1:0]        wr_sel,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    input  logic [DATA_W-1:0] rd_data,
    output logic              tune_start,
    output logic [CH_W-1:0]   tune_ch,
    output logic              overrun
);

    localparam int NDIG  = DATA_W / 4;
    localparam int CNT_W = (NDIG < 2) ? 1 : $clog2(NDIG + 1);

    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_A  = 8'h41;
    localparam logic [7:0] CHR_N  = 8'h4E;

    typedef enum logic [3:0] {
        S_IDLE, S_CHAN, S_RSEL, S_DATA, S_EXP_CR,
        S_SKIP, S_ACK, S_RD_WAIT, S_RD_SEND, S_RD_CR
    } state_t;

    typedef enum logic [1:0] {
        K_WRITE, K_TUNE, K_READ
    } kind_t;

    state_t            state;
    state_t            state_next;
    kind_t             kind;
    logic [1:0]        sel;
    logic [CH_W-1:0]   ch;
    // Collects hex digits while parsing; reused as the readback shifter.
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  cnt;
    logic              ack_ok;

    // Byte classification of rx_data
    logic              is_cr;
    logic              is_lf;
    logic              rx_fire;
    logic              hex_ok;
    logic [3:0]        hex_nib;
    logic              ch_ok;
    logic [CH_W-1:0]   ch_idx;
    logic              sel_ok;
    logic [1:0]        sel_code;
    logic              is_tune;
    logic              is_read;
    logic              cnt_last;
    logic              resp_busy;
    logic [3:0]        out_nib;

    always_comb begin
        is_cr    = (rx_data == CHR_CR);
        is_lf    = (rx_data == CHR_LF);
        rx_fire  = rx_valid && !is_lf;
        hex_ok   = 1'b0;
        hex_nib  = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            hex_ok  = 1'b1;
            hex_nib = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 gives 10..15
            hex_ok  = 1'b1;
            hex_nib = rx_data[3:0] + 4'd9;
        end
        ch_ok    = (rx_data[7:4] == 4'h3) && ({4'h0, rx_data[3:0]} < 8'(NUM_CH));
        ch_idx   = CH_W'(rx_data[3:0]);
        sel_ok   = 1'b1;
        sel_code = 2'd0;
        case (rx_data)
            8'h4B:   sel_code = 2'd0;   // 'K'
            8'h49:   sel_code = 2'd1;   // 'I'
            8'h44:   sel_code = 2'd2;   // 'D'
            8'h53:   sel_code = 2'd3;   // 'S'
            default: sel_ok   = 1'b0;
        endcase
        is_tune   = (rx_data == 8'h54); // 'T'
        is_read   = (rx_data == 8'h52); // 'R'
        cnt_last  = (cnt == CNT_W'(NDIG - 1));
        resp_busy = (state == S_ACK) || (state == S_RD_WAIT) ||
                    (state == S_RD_SEND) || (state == S_RD_CR);
        out_nib   = shift[DATA_W-1 -: 4];
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and TX outputs
    always_comb begin
        state_next = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            S_IDLE: begin
                if (rx_fire) begin
                    if (sel_ok || is_tune || is_read) state_next = S_CHAN;
                    else if (is_cr)                   state_next = S_IDLE;
                    else                              state_next = S_SKIP;
                end
            end
            S_CHAN: begin
                // A CR here is just another non-digit; the line is then
                // discarded up to the following CR.
                if (rx_fire) begin
                    if (!ch_ok)               state_next = S_SKIP;
                    else if (kind == K_WRITE) state_next = S_DATA;
                    else if (kind == K_TUNE)  state_next = S_EXP_CR;
                    else                      state_next = S_RSEL;
                end
            end
            S_RSEL: begin
                if (rx_fire) state_next = sel_ok ? S_EXP_CR : S_SKIP;
            end
            S_DATA: begin
                if (rx_fire) begin
                    if (hex_ok)     state_next = cnt_last ? S_EXP_CR : S_DATA;
                    else if (is_cr) state_next = S_ACK;
                    else            state_next = S_SKIP;
                end
            end
            S_EXP_CR: begin
                if (rx_fire) begin
                    if (!is_cr)              state_next = S_SKIP;
                    else if (kind == K_READ) state_next = S_RD_WAIT;
                    else                     state_next = S_ACK;
                end
            end
            S_SKIP: begin
                if (rx_fire && is_cr) state_next = S_ACK;
            end
            S_ACK: begin
                tx_valid = 1'b1;
                tx_data  = ack_ok ? CHR_A : CHR_N;
                if (tx_ready) state_next = S_IDLE;
            end
            S_RD_WAIT: begin
                // First cycle here carries rd_req; data is taken on the next.
                if (!rd_req) state_next = S_RD_SEND;
            end
            S_RD_SEND: begin
                tx_valid = 1'b1;
                tx_data  = (out_nib < 4'd10) ? {4'h3, out_nib}
                                             : (8'h37 + {4'h0, out_nib});
                if (tx_ready && cnt_last) state_next = S_RD_CR;
            end
            S_RD_CR: begin
                tx_valid = 1'b1;
                tx_data  = CHR_CR;
                if (tx_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath, strobes and sticky flag
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            kind       <= K_WRITE;
            sel        <= 2'd0;
            ch         <= '0;
            shift      <= '0;
            cnt        <= '0;
            ack_ok     <= 1'b0;
            wr_en      <= 1'b0;
            wr_ch      <= '0;
            wr_sel     <= 2'd0;
            wr_data    <= '0;
            rd_req     <= 1'b0;
            tune_start <= 1'b0;
            tune_ch    <= '0;
            overrun    <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            rd_req     <= 1'b0;
            tune_start <= 1'b0;
            if (rx_valid && resp_busy) overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (rx_fire && (sel_ok || is_tune || is_read)) begin
                        kind  <= is_tune ? K_TUNE : (is_read ? K_READ : K_WRITE);
                        sel   <= sel_code;
                        shift <= '0;
                        cnt   <= '0;
                    end
                end
                S_CHAN: begin
                    if (rx_fire && ch_ok) ch <= ch_idx;
                end
                S_RSEL: begin
                    if (rx_fire && sel_ok) sel <= sel_code;
                end
                S_DATA: begin
                    if (rx_fire && hex_ok) begin
                        shift <= (shift << 4) | DATA_W'(hex_nib);
                        cnt   <= cnt + 1'b1;
                    end else if (rx_fire && is_cr) begin
                        ack_ok <= 1'b0;
                    end
                end
                S_EXP_CR: begin
                    if (rx_fire && is_cr) begin
                        ack_ok <= 1'b1;
                        case (kind)
                            K_WRITE: begin
                                wr_en   <= 1'b1;
                                wr_ch   <= ch;
                                wr_sel  <= sel;
                                wr_data <= shift;
                            end
                            K_TUNE: begin
                                tune_start <= 1'b1;
                                tune_ch    <= ch;
                            end
                            default: begin
                                rd_req <= 1'b1;
                                wr_ch  <= ch;
                                wr_sel <= sel;
                            end
                        endcase
                    end
                end
                S_SKIP: begin
                    if (rx_fire && is_cr) ack_ok <= 1'b0;
                end
                S_RD_WAIT: begin
                    if (!rd_req) begin
                        shift <= rd_data;
                        cnt   <= '0;
                    end
                end
                S_RD_SEND: begin
                    if (tx_ready) begin
                        shift <= shift << 4;
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
